ro_puf_eval: RTL

- Parametrised ring-oscillator PUF evaluator, successor to the single-pair mux/counter/compare path.
- Takes N_RO free-running oscillator outputs, instantiated outside this block. For each response bit:
  - expands a 16-bit challenge seed with an LFSR into oscillator pair selections;
  - counts synchronised rising edges of both selected oscillators over a programmable clk window;
  - compares the two counts.
- Assembles RESP_W bits and presents them with a valid/ready handshake to the top-level I/O wrapper.

---
 rtl/ro_puf_pkg.sv | 30 +++
 rtl/ro_puf_eval_counter.sv | 66 ++++++
 rtl/ro_puf_eval.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg
//   Shared definitions for the ring-oscillator PUF evaluator: the FSM state
//   encoding, the challenge-expansion LFSR polynomial and default seed, and
//   the LFSR step function used by the top level.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } state_t;

  localparam int CHAL_W = 16;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1, bit 15 being x^16.
  localparam logic [CHAL_W-1:0] LFSR_TAPS = 16'hB400;

  // Substituted for an all-zero challenge, which would lock the LFSR at zero.
  localparam logic [CHAL_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One Fibonacci step: the parity of the tapped bits enters at bit 0 and
  // the register shifts toward the MSB.
  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] cur);
    return {cur[CHAL_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ro_puf_eval_counter.sv
// ro_edge_counter
//   One measurement channel: synchronises a free-running oscillator into the
//   clk domain, detects its rising edges and counts them with saturation.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous reset, active-high despite the name
//   i_clr        zero the counter and the saturation flag
//   i_en         count window open
//   i_ro         raw oscillator, asynchronous to i_clk
//   o_count      edges seen while i_en was high
//   o_saturated  an edge arrived while the counter was already all-ones
module ro_edge_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_ro,
  output logic [CNT_W-1:0] o_count,
  output logic             o_saturated
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_count;
  logic                   r_saturated;
  logic                   w_rise;

  // The synchroniser chain and the edge-detect flop run continuously so a
  // freshly selected oscillator has settled before the window opens.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Saturating counter: at all-ones further edges are dropped and flagged
  // rather than wrapping, so a saturated count can never compare as small.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_count     <= '0;
      r_saturated <= 1'b0;
    end else if (i_clr) begin
      r_count     <= '0;
      r_saturated <= 1'b0;
    end else if (i_en && w_rise) begin
      if (&r_count) begin
        r_saturated <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count     = r_count;
  assign o_saturated = r_saturated;

endmodule

// File: rtl/ro_puf_eval.sv
// ro_puf_eval
//   Ring-oscillator PUF evaluator. For each of RESP_W response bits a pair of
//   oscillators is chosen from an LFSR expanded from the challenge, both are
//   edge-counted over a programmable window and the counts are compared.
//   Oscillators faster than clk/2 alias; this is an accepted limitation.
// Ports:
//   i_clk, i_rst_n        clock; asynchronous active-high reset
//   i_ro_in               N_RO raw oscillator outputs
//   i_start               request an evaluation (looked at only in IDLE)
//   i_challenge           LFSR seed, latched on start accept
//   i_win_len             window length in clk cycles, 0 behaves as 1
//   o_busy                high whenever the FSM is not in IDLE
//   o_resp_valid          response word is available
//   i_resp_ready          consumer takes the response (looked at only in DONE)
//   o_resp                response, bit i is the i-th evaluated pair
//   o_ties                number of pairs whose counts were equal
//   o_sat                 some counter saturated during this evaluation
//   o_cnt_a, o_cnt_b      counts of the most recently compared pair
module ro_puf_eval
  import ro_puf_pkg::*;
#(
  parameter int N_RO        = 16,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int RESP_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_RO-1:0]              i_ro_in,
  input  logic                         i_start,
  input  logic [CHAL_W-1:0]            i_challenge,
  input  logic [WIN_W-1:0]             i_win_len,
  output logic                         o_busy,
  output logic                         o_resp_valid,
  input  logic                         i_resp_ready,
  output logic [RESP_W-1:0]            o_resp,
  output logic [$clog2(RESP_W+1)-1:0]  o_ties,
  output logic                         o_sat,
  output logic [CNT_W-1:0]             o_cnt_a,
  output logic [CNT_W-1:0]             o_cnt_b
);

  localparam int SEL_W = $clog2(N_RO);
  localparam int TIE_W = $clog2(RESP_W+1);
  localparam int SET_W = $clog2(SYNC_STAGES+1);
  localparam logic [SEL_W:0] N_RO_V = (SEL_W+1)'(N_RO);

  state_t            r_state;
  logic [CHAL_W-1:0] r_lfsr;
  logic [WIN_W-1:0]  r_winLen;
  logic [WIN_W-1:0]  r_winCnt;
  logic [SET_W-1:0]  r_settleCnt;
  logic [TIE_W-1:0]  r_idx;
  logic [SEL_W-1:0]  r_selA;
  logic [SEL_W-1:0]  r_selB;
  logic              r_busy;
  logic              r_valid;
  logic [RESP_W-1:0] r_resp;
  logic [TIE_W-1:0]  r_ties;
  logic              r_sat;
  logic [CNT_W-1:0]  r_cntA;
  logic [CNT_W-1:0]  r_cntB;

  logic [SEL_W-1:0]  w_selA;
  logic [SEL_W-1:0]  w_selB;
  logic [SEL_W-1:0]  w_rawB;
  logic              w_roA;
  logic              w_roB;
  logic              w_clr;
  logic              w_en;
  logic [CNT_W-1:0]  w_cntA;
  logic [CNT_W-1:0]  w_cntB;
  logic              w_satA;
  logic              w_satB;

  // A SEL_W-bit field is always below 2*N_RO, so one conditional subtract
  // is a full modulo-N_RO reduction for non-power-of-two N_RO.
  function automatic logic [SEL_W-1:0] foldSel(input logic [SEL_W-1:0] raw);
    if ({1'b0, raw} >= N_RO_V) begin
      return raw - N_RO_V[SEL_W-1:0];
    end
    return raw;
  endfunction

  // Pair selection from the low LFSR bits; a self-pair is bumped to the
  // next oscillator so every bit compares two distinct rings.
  assign w_selA = foldSel(r_lfsr[SEL_W-1:0]);
  assign w_rawB = foldSel(r_lfsr[2*SEL_W-1:SEL_W]);
  assign w_selB = (w_rawB != w_selA)                  ? w_rawB :
                  (w_selA == SEL_W'(N_RO-1))          ? '0     :
                                                        w_selA + 1'b1;

  assign w_roA = i_ro_in[r_selA];
  assign w_roB = i_ro_in[r_selB];
  assign w_clr = (r_state == CLEAR);
  assign w_en  = (r_state == COUNT);

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cntA (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_clr),
    .i_en        (w_en),
    .i_ro        (w_roA),
    .o_count     (w_cntA),
    .o_saturated (w_satA)
  );

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cntB (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_clr),
    .i_en        (w_en),
    .i_ro        (w_roB),
    .o_count     (w_cntB),
    .o_saturated (w_satB)
  );

  // Evaluation sequencer. Each bit costs CLEAR(1) + SETTLE(SYNC_STAGES+1) +
  // COUNT(W) + COMPARE(1) cycles. SETTLE lets the new mux selection pass the
  // synchroniser and edge flop so the switch itself is never counted.
  // resp_valid and busy are registered here alongside the state.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_state     <= IDLE;
      r_lfsr      <= '0;
      r_winLen    <= '0;
      r_winCnt    <= '0;
      r_settleCnt <= '0;
      r_idx       <= '0;
      r_selA      <= '0;
      r_selB      <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_resp      <= '0;
      r_ties      <= '0;
      r_sat       <= 1'b0;
      r_cntA      <= '0;
      r_cntB      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_lfsr   <= (i_challenge == '0) ? LFSR_DEFAULT_SEED : i_challenge;
            r_winLen <= (i_win_len == '0) ? WIN_W'(1) : i_win_len;
            r_resp   <= '0;
            r_ties   <= '0;
            r_sat    <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CLEAR;
          end
        end
        CLEAR: begin
          r_selA      <= w_selA;
          r_selB      <= w_selB;
          r_settleCnt <= SET_W'(SYNC_STAGES);
          r_state     <= SETTLE;
        end
        SETTLE: begin
          if (r_settleCnt == '0) begin
            r_winCnt <= r_winLen;
            r_state  <= COUNT;
          end else begin
            r_settleCnt <= r_settleCnt - 1'b1;
          end
        end
        COUNT: begin
          if (r_winCnt == WIN_W'(1)) begin
            r_state <= COMPARE;
          end else begin
            r_winCnt <= r_winCnt - 1'b1;
          end
        end
        COMPARE: begin
          if (w_cntA > w_cntB) begin
            r_resp <= r_resp | (RESP_W'(1) << r_idx);
          end
          if (w_cntA == w_cntB) begin
            r_ties <= r_ties + 1'b1;
          end
          r_sat  <= r_sat | w_satA | w_satB;
          r_cntA <= w_cntA;
          r_cntB <= w_cntB;
          r_lfsr <= lfsr_next(r_lfsr);
          r_idx  <= r_idx + 1'b1;
          if (r_idx == TIE_W'(RESP_W-1)) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= CLEAR;
          end
        end
        DONE: begin
          if (i_resp_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_resp_valid = r_valid;
  assign o_resp       = r_resp;
  assign o_ties       = r_ties;
  assign o_sat        = r_sat;
  assign o_cnt_a      = r_cntA;
  assign o_cnt_b      = r_cntB;

endmodule
